// File: rtl/vga_scanout.sv
// VGA scan-out timing generator. A half-rate pixel clock is derived from clk by
// a phase toggle. The block walks the full line/frame raster, issues a
// column-major framebuffer address, and presents registered pixel, coordinate
// and sync outputs one pixel period later.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fb_valid,
    input  logic [23:0] fb_out,
    output logic [19:0] fb_read,
    output logic [23:0] pixel,
    output logic [9:0]  counterX,
    output logic [9:0]  counterY,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_start
);

    // Raster boundaries, pre-sized to the 10-bit counters.
    localparam logic [9:0]  H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0]  H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // Memory is stored column-major: one column holds V_ACTIVE pixels.
    localparam logic [19:0] ADDR_STRIDE  = 20'(V_ACTIVE);

    logic        r_tick;
    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [23:0] r_pixel;
    logic [9:0]  r_counter_x;
    logic [9:0]  r_counter_y;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_frame_start;

    logic [9:0]  w_hcount_nxt;
    logic [9:0]  w_vcount_nxt;
    logic        w_visible;
    logic        w_hsync;
    logic        w_vsync;
    logic        w_origin;
    logic [19:0] w_addr;

    // Raster position that follows the current one.
    always_comb begin
        w_hcount_nxt = r_hcount + 10'd1;
        w_vcount_nxt = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = '0;
            if (r_vcount == V_LAST) begin
                w_vcount_nxt = '0;
            end else begin
                w_vcount_nxt = r_vcount + 10'd1;
            end
        end
    end

    // Decode of the current position: visibility, syncs, origin and read address.
    always_comb begin
        w_visible = (r_hcount < H_VIS) && (r_vcount < V_VIS);
        w_hsync   = !((r_hcount >= H_SYNC_START) && (r_hcount < H_SYNC_END));
        w_vsync   = !((r_vcount >= V_SYNC_START) && (r_vcount < V_SYNC_END));
        w_origin  = (r_hcount == '0) && (r_vcount == '0);
        w_addr    = '0;
        if (w_visible) begin
            w_addr = 20'(r_hcount) * ADDR_STRIDE + 20'(r_vcount);
        end
    end

    // Address depends only on the raster counters, so it stays put for both
    // clk phases of a pixel and read data is back in time for the tick=1 edge.
    assign fb_read = w_addr;

    // Phase toggle and raster counters; counters step once per pixel period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick   <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                r_hcount <= w_hcount_nxt;
                r_vcount <= w_vcount_nxt;
            end
        end
    end

    // Output registers: capture the current pixel on tick=1, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel       <= '0;
            r_counter_x   <= '0;
            r_counter_y   <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (r_tick) begin
                r_counter_x   <= r_hcount;
                r_counter_y   <= r_vcount;
                r_active      <= w_visible;
                r_hsync       <= w_hsync;
                r_vsync       <= w_vsync;
                r_frame_start <= w_origin;
                // Blank while the frame memory is not yet trustworthy.
                r_pixel       <= (w_visible && fb_valid) ? fb_out : 24'h000000;
            end
        end
    end

    assign pixel       = r_pixel;
    assign counterX    = r_counter_x;
    assign counterY    = r_counter_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign frame_start = r_frame_start;

endmodule
